// File: rtl/logistic_pio_source_if.sv
// PIO link between fillBuffer and the logistic stimulus source.
// outputPio carries request codes from fillBuffer; inputPio carries the tagged response words.
interface logistic_pio_source_if;
  // Handshake: a request is the level of outputPio equal to a request code.
  // It is sampled only while the source waits for that code, so a request that
  // stays high gives exactly one response. inputPio holds its last response
  // until the next one is driven.
  logic [31:0] outputPio;
  logic [31:0] inputPio;

  modport master (
    output outputPio,
    input  inputPio
  );

  modport slave (
    input  outputPio,
    output inputPio
  );
endinterface

// File: rtl/logistic_pio_source.sv
// Logistic-map stimulus source: serves x(n+1)=R*x*(1-x) samples as tagged half-words over PIO.
// Optional running sum of the sent samples when LOGISTIC_PIO_CHECKSUM_EN is defined.
module logistic_pio_source #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       FRAC_BITS   = 28,
  parameter logic [DATA_W-1:0] R_COEF      = DATA_W'(32'h40000000),
  parameter logic [DATA_W-1:0] SEED        = DATA_W'(32'h03e44970),
  parameter int unsigned       NUM_SAMPLES = 512,
  parameter logic [31:0]       REQ_HI      = 32'h00000006,
  parameter logic [31:0]       REQ_LO      = 32'h00000003,
  parameter logic [15:0]       TAG_HI      = 16'h0045,
  parameter logic [15:0]       TAG_LO      = 16'h0048,
  parameter int unsigned       RESP_DELAY  = 40
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      start,
  logistic_pio_source_if.slave      pio,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               sample_idx,
  output logic [DATA_W-1:0]         x_cur,
`ifdef LOGISTIC_PIO_CHECKSUM_EN
  output logic [DATA_W-1:0]         checksum,
`endif
  output logic [2:0]                state_dbg
);

  localparam int unsigned HALF_W = DATA_W / 2;
  localparam int unsigned CNT_W  = (RESP_DELAY < 1) ? 1 : $clog2(RESP_DELAY + 1);
  localparam logic [2*DATA_W-1:0] ONE_W = (2*DATA_W)'(1) << FRAC_BITS;
  localparam logic [15:0] LAST_IDX = 16'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_HI = 3'd1,
    HOLD_HI = 3'd2,
    WAIT_LO = 3'd3,
    HOLD_LO = 3'd4,
    COMPUTE = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pio_q, pio_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  x_q, x_d;
  logic [15:0]        idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef LOGISTIC_PIO_CHECKSUM_EN
  logic [DATA_W-1:0]  csum_q, csum_d;
`endif

  // Next-sample arithmetic: unsigned, double-width, floor at each shift.
  logic [2*DATA_W-1:0] x_ext;
  logic [2*DATA_W-1:0] t_w;
  logic [2*DATA_W-1:0] d_w;
  logic [DATA_W-1:0]   next_x;
  logic [31:0]         resp_hi;
  logic [31:0]         resp_lo;

  always_comb begin
    x_ext  = {{DATA_W{1'b0}}, x_q};
    t_w    = (x_ext * (2*DATA_W)'(R_COEF)) >> FRAC_BITS;
    d_w    = (x_ext >= ONE_W) ? '0 : (ONE_W - x_ext);
    next_x = DATA_W'((t_w * d_w) >> FRAC_BITS);
    resp_hi = 32'({TAG_HI, x_q[DATA_W-1:HALF_W]});
    resp_lo = 32'({TAG_LO, x_q[HALF_W-1:0]});
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      pio_q   <= '0;
      cnt_q   <= '0;
      x_q     <= SEED;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LOGISTIC_PIO_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pio_q   <= pio_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef LOGISTIC_PIO_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pio_d   = pio_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef LOGISTIC_PIO_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          x_d     = SEED;
          idx_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef LOGISTIC_PIO_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (pio.outputPio == REQ_HI) begin
          cnt_d   = CNT_W'(RESP_DELAY);
          state_d = HOLD_HI;
        end
      end
      HOLD_HI: begin
        if (cnt_q == '0) begin
          pio_d   = resp_hi;
          state_d = WAIT_LO;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (pio.outputPio == REQ_LO) begin
          cnt_d   = CNT_W'(RESP_DELAY);
          state_d = HOLD_LO;
        end
      end
      HOLD_LO: begin
        if (cnt_q == '0) begin
          pio_d   = resp_lo;
          state_d = COMPUTE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      COMPUTE: begin
`ifdef LOGISTIC_PIO_CHECKSUM_EN
        csum_d = csum_q + x_q;
`endif
        if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          x_d     = next_x;
          idx_d   = idx_q + 16'd1;
          state_d = WAIT_HI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pio.inputPio = pio_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_idx   = idx_q;
  assign x_cur        = x_q;
  assign state_dbg    = state_q;
`ifdef LOGISTIC_PIO_CHECKSUM_EN
  assign checksum     = csum_q;
`endif

endmodule

// File: tb/tb_logistic_pio_source.sv
// Directed bench for logistic_pio_source: three instances (default seed, seed 0, seed ONE).
// Checksum checks are compiled in when LOGISTIC_PIO_CHECKSUM_EN is defined.
module tb_logistic_pio_source;

  localparam logic [31:0] REQ_HI = 32'h00000006;
  localparam logic [31:0] REQ_LO = 32'h00000003;
  localparam logic [31:0] ONE    = 32'h10000000;
  localparam logic [31:0] SEED   = 32'h03e44970;
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT_HI = 3'd1, S_WAIT_LO = 3'd3,
                         S_HOLD_HI = 3'd2, S_HOLD_LO = 3'd4, S_COMPUTE = 3'd5, S_DONE = 3'd6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic start_a, start_bc;
  logic [31:0] req_bc;

  logistic_pio_source_if a_if();
  logistic_pio_source_if b_if();
  logistic_pio_source_if c_if();
  assign b_if.outputPio = req_bc;
  assign c_if.outputPio = req_bc;

  logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic [15:0] idx_a, idx_b, idx_c;
  logic [31:0] x_a, x_b, x_c;
  logic [2:0]  st_a, st_b, st_c;
`ifdef LOGISTIC_PIO_CHECKSUM_EN
  logic [31:0] cs_a, cs_b, cs_c;
`endif

  logistic_pio_source #(.NUM_SAMPLES(3)) dut_a (
    .CLOCK_50(clk), .reset(rst), .start(start_a), .pio(a_if.slave),
    .busy(busy_a), .done(done_a), .sample_idx(idx_a), .x_cur(x_a),
`ifdef LOGISTIC_PIO_CHECKSUM_EN
    .checksum(cs_a),
`endif
    .state_dbg(st_a));

  logistic_pio_source #(.SEED(32'h0), .NUM_SAMPLES(2), .RESP_DELAY(0)) dut_b (
    .CLOCK_50(clk), .reset(rst), .start(start_bc), .pio(b_if.slave),
    .busy(busy_b), .done(done_b), .sample_idx(idx_b), .x_cur(x_b),
`ifdef LOGISTIC_PIO_CHECKSUM_EN
    .checksum(cs_b),
`endif
    .state_dbg(st_b));

  logistic_pio_source #(.SEED(32'h10000000), .NUM_SAMPLES(2), .RESP_DELAY(0)) dut_c (
    .CLOCK_50(clk), .reset(rst), .start(start_bc), .pio(c_if.slave),
    .busy(busy_c), .done(done_c), .sample_idx(idx_c), .x_cur(x_c),
`ifdef LOGISTIC_PIO_CHECKSUM_EN
    .checksum(cs_c),
`endif
    .state_dbg(st_c));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] next_x(input logic [31:0] x);
    logic [63:0] t, d, p;
    t = ({32'h0, x} * 64'h40000000) >> 28;
    d = ({32'h0, x} >= {32'h0, ONE}) ? 64'h0 : ({32'h0, ONE} - {32'h0, x});
    p = (t * d) >> 28;
    return p[31:0];
  endfunction

  task automatic bc_req(input logic [31:0] code);
    req_bc = code;
    tick();
    req_bc = 32'h0;
    tick();
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] code;
    int          hold;
    bit          resp;
    logic [31:0] exp_pio;
    logic [2:0]  exp_state;
  } vec_t;

  vec_t        vecs [11];
  logic [31:0] xexp [3];
  logic [31:0] c_hi [2];
  logic [31:0] c_lo [2];
  logic [31:0] last_pio;
  int          k_s;

  initial begin
    xexp[0] = SEED;
    xexp[1] = 32'h0BC7D2DE;
    xexp[2] = next_x(32'h0BC7D2DE);
    vecs[0]  = '{REQ_HI,       10, 1'b1, 32'h004503E4, S_WAIT_LO};
    vecs[1]  = '{REQ_HI,        5, 1'b0, 32'h0,        S_WAIT_LO};
    vecs[2]  = '{32'h00000005,  3, 1'b0, 32'h0,        S_WAIT_LO};
    vecs[3]  = '{REQ_LO,        1, 1'b1, 32'h00484970, S_COMPUTE};
    vecs[4]  = '{REQ_LO,        4, 1'b0, 32'h0,        S_WAIT_HI};
    vecs[5]  = '{REQ_HI,       41, 1'b1, 32'h00450BC7, S_WAIT_LO};
    vecs[6]  = '{REQ_LO,        2, 1'b1, 32'h0048D2DE, S_COMPUTE};
    vecs[7]  = '{REQ_HI,        1, 1'b1, {16'h0045, xexp[2][31:16]}, S_WAIT_LO};
    vecs[8]  = '{REQ_LO,        1, 1'b1, {16'h0048, xexp[2][15:0]},  S_COMPUTE};
    vecs[9]  = '{REQ_HI,       20, 1'b0, 32'h0,        S_DONE};
    vecs[10] = '{REQ_LO,       20, 1'b0, 32'h0,        S_DONE};
    c_hi[0] = 32'h00451000; c_lo[0] = 32'h00480000;
    c_hi[1] = 32'h00450000; c_lo[1] = 32'h00480000;

    // Reset, with start asserted in the last reset cycle: reset must win.
    rst = 1'b1; start_a = 1'b0; start_bc = 1'b0; req_bc = 32'h0; a_if.outputPio = 32'h0;
    repeat (2) tick();
    start_a = 1'b1;
    tick();
    rst = 1'b0; start_a = 1'b0;
    check("reset_state", {29'h0, st_a}, {29'h0, S_IDLE});
    check("reset_pio", a_if.inputPio, 32'h0);
    check("reset_busy_done", {30'h0, busy_a, done_a}, 32'h0);
    check("reset_idx", {16'h0, idx_a}, 32'h0);
    check("reset_x_a", x_a, SEED);
    check("reset_x_c", x_c, ONE);

    // Seed 0 and seed ONE, zero response delay, two samples each.
    start_bc = 1'b1;
    tick();
    start_bc = 1'b0;
    check("bc_start_state", {29'h0, st_b}, {29'h0, S_WAIT_HI});
    for (int k = 0; k < 2; k++) begin
      bc_req(REQ_HI);
      check("b_hi", b_if.inputPio, 32'h00450000);
      check("c_hi", c_if.inputPio, c_hi[k]);
      bc_req(REQ_LO);
      check("b_lo", b_if.inputPio, 32'h00480000);
      check("c_lo", c_if.inputPio, c_lo[k]);
      tick();
      if (k == 0) begin
        check("b_x1", x_b, 32'h0);
        check("c_x1_zero", x_c, 32'h0);
        check("c_idx1", {16'h0, idx_c}, 32'h1);
      end else begin
        check("bc_done", {28'h0, done_b, busy_b, done_c, busy_c}, 32'hA);
      end
    end
`ifdef LOGISTIC_PIO_CHECKSUM_EN
    check("b_checksum", cs_b, 32'h0);
    check("c_checksum", cs_c, ONE);
`endif

    // Default seed and delay, three samples, table-driven request sequence.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("a_start", {28'h0, busy_a, st_a}, {28'h0, 1'b1, S_WAIT_HI});
    last_pio = 32'h0;
    k_s = 0;
    for (int i = 0; i < 11; i++) begin
      a_if.outputPio = vecs[i].code;
      if (vecs[i].resp) begin
        for (int t = 1; t <= 41; t++) begin
          tick();
          if (t == vecs[i].hold) a_if.outputPio = 32'h0;
        end
        check($sformatf("pre_resp_%0d", i), a_if.inputPio, last_pio);
        tick();
        check($sformatf("resp_%0d", i), a_if.inputPio, vecs[i].exp_pio);
        check($sformatf("resp_state_%0d", i), {29'h0, st_a}, {29'h0, vecs[i].exp_state});
        last_pio = vecs[i].exp_pio;
        if (vecs[i].code == REQ_LO) begin
          tick();
          k_s++;
          if (k_s < 3) begin
            check($sformatf("x_%0d", k_s), x_a, xexp[k_s]);
            check($sformatf("idx_%0d", k_s), {16'h0, idx_a}, k_s);
            check($sformatf("next_state_%0d", k_s), {29'h0, st_a}, {29'h0, S_WAIT_HI});
          end else begin
            check("done_busy", {30'h0, done_a, busy_a}, 32'h2);
            check("done_state", {29'h0, st_a}, {29'h0, S_DONE});
          end
        end
      end else begin
        for (int t = 0; t < vecs[i].hold; t++) tick();
        a_if.outputPio = 32'h0;
        check($sformatf("ignored_pio_%0d", i), a_if.inputPio, last_pio);
        check($sformatf("ignored_state_%0d", i), {29'h0, st_a}, {29'h0, vecs[i].exp_state});
      end
    end
`ifdef LOGISTIC_PIO_CHECKSUM_EN
    check("a_checksum", cs_a, xexp[0] + xexp[1] + xexp[2]);
`endif
    check("done_held", {31'h0, done_a}, 32'h1);

    // Restart from DONE, then reset while the low half is pending.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("restart_x", x_a, SEED);
    check("restart_idx", {16'h0, idx_a}, 32'h0);
    a_if.outputPio = REQ_HI;
    tick();
    a_if.outputPio = 32'h0;
    check("restart_hold_hi", {29'h0, st_a}, {29'h0, S_HOLD_HI});
    repeat (41) tick();
    check("restart_hi", a_if.inputPio, 32'h004503E4);
    a_if.outputPio = REQ_LO;
    tick();
    a_if.outputPio = 32'h0;
    check("in_hold_lo", {29'h0, st_a}, {29'h0, S_HOLD_LO});
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_pio", a_if.inputPio, 32'h0);
    check("midrst_state", {29'h0, st_a}, {29'h0, S_IDLE});
    check("midrst_x", x_a, SEED);
    repeat (60) tick();
    check("midrst_no_partial", a_if.inputPio, 32'h0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("post_rst_start", {28'h0, busy_a, st_a}, {28'h0, 1'b1, S_WAIT_HI});
    check("post_rst_idx", {16'h0, idx_a}, 32'h0);
    a_if.outputPio = REQ_HI;
    tick();
    a_if.outputPio = 32'h0;
    repeat (41) tick();
    check("post_rst_hi", a_if.inputPio, 32'h004503E4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/logistic_pio_source.md
Name: logistic_pio_source

Overview:
- Synthesizable, parametrised stimulus source for the fillBuffer PIO link; supersedes the fixed-function fake sender.
- Generates NUM_SAMPLES values of the fixed-point map x(n+1) = R·x(n)·(1−x(n)).
- Sends each sample as two tagged half-words over the inputPio/outputPio request/response handshake.
- Sits between fillBuffer's outputPio (request codes) and its inputPio (response words); usable on-chip or in simulation.

Parameters:
- DATA_W, 32: sample width; must be even; the half-word width is DATA_W/2.
- FRAC_BITS, 28: fractional bits of the fixed-point format; ONE = 1<<FRAC_BITS.
- R_COEF, 32'h40000000: map coefficient R, in the same Q format (default value is 4.0).
- SEED, 32'h03e44970: x(0), loaded at reset and on every start.
- NUM_SAMPLES, 512: samples sent per run (≥1).
- REQ_HI, 32'h00000006: outputPio code requesting the high half.
- REQ_LO, 32'h00000003: outputPio code requesting the low half.
- TAG_HI, 16'h0045: tag in inputPio[31:16] for the high half.
- TAG_LO, 16'h0048: tag in inputPio[31:16] for the low half.
- RESP_DELAY, 40: cycles between request detection and response drive (≥0).

Ports:
- CLOCK_50, in, 1: single clock; all logic on the rising edge.
- reset, in, 1: synchronous, active-high.
- start, in, 1: one-cycle pulse that begins a run.
- outputPio, in, 32: request code from fillBuffer.
- inputPio, out, 32: response word {tag, half-word}, zero-extended to 32 bits.
- busy, out, 1: high from start acceptance until done.
- done, out, 1: high after the last low half has been sent; held until the next start.
- sample_idx, out, 16: index of the sample currently being sent.
- x_cur, out, DATA_W: current sample value.

Behaviour:
- Reset, synchronous: state=IDLE, inputPio=0, busy=0, done=0, sample_idx=0, x_cur=SEED, delay counter=0.
- IDLE or DONE, start=1: x_cur←SEED, sample_idx←0, done←0, busy←1, go to WAIT_HI. Start is ignored in every other state.
- WAIT_HI: when outputPio==REQ_HI, load the delay counter with RESP_DELAY and go to HOLD_HI.
- HOLD_HI: count down. When the count is 0, drive inputPio = {TAG_HI, x_cur[DATA_W-1:DATA_W/2]} (zero-extended) and go to WAIT_LO. With RESP_DELAY=0, the response drives on the cycle after detection.
- WAIT_LO and HOLD_LO: identical to WAIT_HI/HOLD_HI, using REQ_LO and {TAG_LO, x_cur[DATA_W/2-1:0]}.
- After the low half is driven, go to COMPUTE.
- COMPUTE, one cycle:
  - If sample_idx==NUM_SAMPLES−1: busy←0, done←1, go to DONE.
  - Otherwise: x_cur←next, sample_idx+1, go to WAIT_HI.
- inputPio holds its last driven value in every state; it is never cleared except by reset.
- Arithmetic for next:
  - Unsigned, with 2·DATA_W-bit intermediates.
  - t = (x_cur·R_COEF)>>FRAC_BITS.
  - d = (x_cur ≥ ONE) ? 0 : ONE−x_cur.
  - next = (t·d)>>FRAC_BITS, truncated to DATA_W bits. No rounding; floor only.
- Request levels are evaluated only in the matching WAIT state:
  - A request code held high across several cycles yields exactly one response.
  - A REQ_LO seen while in WAIT_HI is ignored, and vice versa.
  - Any other outputPio value is ignored.
- Fixed point x=0 is legal and remains 0 for the rest of the run.
- Reset mid-run aborts immediately to the reset values; no partial response completes.
- start and reset in the same cycle: reset wins.

Optional Feature:
- Macro LOGISTIC_PIO_CHECKSUM_EN.
- Defined:
  - Extra output port checksum, DATA_W bits.
  - Cleared by reset and on start acceptance.
  - In each COMPUTE cycle, checksum ← checksum + x_cur (modulo 2^DATA_W), i.e. the sum of all sent samples.
  - Stable while done=1.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then start with defaults, REQ_HI held for 10 cycles → exactly one response: inputPio=32'h004503E4, RESP_DELAY+1 cycles after detection.
- Then REQ_LO → inputPio=32'h00484970, followed by x_cur=32'h0BC7D2DE; the next pair sent is 32'h00450BC7 / 32'h0048D2DE.
- NUM_SAMPLES=3, full request loop → done rises after the third low half; busy falls the same cycle; further requests leave inputPio unchanged.
- SEED=0 → every response half is 0; run completes normally. SEED=ONE → second sample equals 0.
- Reset asserted in HOLD_LO → inputPio=0 and state=IDLE next cycle; start then restarts from SEED with sample_idx=0.
- With LOGISTIC_PIO_CHECKSUM_EN, NUM_SAMPLES=2, defaults → checksum=32'h0FAC1C4E at done.
